temp_report_sched: RTL and testbench

Periodic measurement and report sequencer between the DS18B20 driver and a byte-wide UART transmitter. Every period it pulses a conversion request and waits for the driver's done pulse, with a timeout. It then latches the 16-bit reading and sign and streams a 5-byte framed report over a valid/ready byte handshake. It replaces the free-running 1 s UART trigger in the top level.

---
 rtl/temp_report_sched.sv | 147 ++++++++++++++
 tb/tb_temp_report_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_report_sched.sv
// Periodic DS18B20 measurement sequencer: requests a conversion every period, waits for the
// result with a timeout, then streams a 5-byte framed report over a valid/ready byte link.
module temp_report_sched #(
  parameter int unsigned PERIOD_CLKS  = 12000000,
  parameter int unsigned TIMEOUT_CLKS = 9600000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  output logic        meas_start,
  input  logic        meas_done,
  input  logic [15:0] temp_data,
  input  logic        sign,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned PW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CLKS - 1);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StSend} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   temp_q, temp_d;
  logic          sign_q, sign_d;
  logic          err_q, err_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    ovr_q, ovr_d;

  logic          tick;
  logic [7:0]    flag_byte;
  logic [7:0]    next_byte;

  assign tick = ena && (period_q == PERIOD_LAST);

  // Phase only advances with ena, so a gap shifts every later tick by its length.
  always_comb begin
    period_d = period_q;
    if (ena) period_d = tick ? '0 : period_q + 1'b1;
  end

  always_comb begin
    ovr_d = ovr_q;
    if (tick && (state_q != StIdle) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 1'b1;
  end

  assign flag_byte = {sign_q, 6'b0, err_q};

  // Byte that follows the one currently presented at index idx_q.
  always_comb begin
    next_byte = '0;
    unique case (idx_q)
      3'd0:    next_byte = flag_byte;
      3'd1:    next_byte = temp_q[15:8];
      3'd2:    next_byte = temp_q[7:0];
      default: next_byte = SYNC_BYTE ^ flag_byte ^ temp_q[15:8] ^ temp_q[7:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tout_d    = tout_q;
    idx_d     = idx_q;
    temp_d    = temp_q;
    sign_d    = sign_q;
    err_d     = err_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (tick) state_d = StStart;
      end
      StStart: begin
        tout_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        tout_d = tout_q + 1'b1;
        if (meas_done || (tout_q == TOUT_LAST)) begin
          state_d   = StSend;
          idx_d     = '0;
          tx_data_d = SYNC_BYTE;
          // A done pulse on the final timeout cycle still counts as a valid reading.
          if (meas_done) begin
            temp_d = temp_data;
            sign_d = sign;
            err_d  = 1'b0;
          end else begin
            temp_d = '0;
            sign_d = 1'b0;
            err_d  = 1'b1;
          end
        end
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q == 3'd4) begin
            state_d = StIdle;
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = next_byte;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      period_q  <= '0;
      tout_q    <= '0;
      idx_q     <= '0;
      temp_q    <= '0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_data_q <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      tout_q    <= tout_d;
      idx_q     <= idx_d;
      temp_q    <= temp_d;
      sign_q    <= sign_d;
      err_q     <= err_d;
      tx_data_q <= tx_data_d;
      ovr_q     <= ovr_d;
    end
  end

  assign meas_start  = (state_q == StStart);
  assign busy        = (state_q != StIdle);
  assign tx_valid    = (state_q == StSend);
  assign tx_data     = tx_data_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_temp_report_sched.sv
// Self-checking bench for temp_report_sched: directed scenarios plus random traffic, checked
// every cycle against a frame-level reference model (tick phase, byte queue, overrun count).
module tb_temp_report_sched;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b0;
  logic        meas_start;
  logic        meas_done = 1'b0;
  logic [15:0] temp_data = '0;
  logic        sign = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [7:0]  overrun_cnt;

  temp_report_sched #(
    .PERIOD_CLKS (PERIOD),
    .TIMEOUT_CLKS(TIMEOUT),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .meas_start (meas_start),
    .meas_done  (meas_done),
    .temp_data  (temp_data),
    .sign       (sign),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver-side controls (written only by the stimulus process).
  int  done_delay   = 0;  // 0 = driver never answers
  int  done_cd      = 0;
  int  rdy_mode     = 0;  // 0 always, 1 random, 2 pattern 0,0,1, 3 never
  int  rdy_ph       = 0;
  bit  rand_mode    = 0;
  bit  chk_first    = 0;
  int  first_exp    = 0;
  bit  sat_probe    = 0;
  bit  wait_expired = 0;

  // Reference model state (written only by the monitor).
  int        m_phase, m_wait_n, m_ovr, n_acc;
  bit        m_start, m_busy, m_waiting, m_valid, first_seen;
  logic [7:0] m_last;
  logic [7:0] exp_q[$];

  task automatic build_frame(input logic [15:0] t, input logic s, input logic e);
    logic [7:0] b1, b2, b3;
    b1 = s * 8'd128 + e;
    b2 = t / 256;
    b3 = t % 256;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(8'hA5 ^ b1 ^ b2 ^ b3);
    m_waiting = 0;
    m_valid   = 1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_tx_valid", tx_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_meas_start", meas_start, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_overrun", overrun_cnt, 0);
      m_phase = 0; m_wait_n = 0; m_ovr = 0; m_last = '0;
      m_start = 0; m_busy = 0; m_waiting = 0; m_valid = 0;
      first_seen = 0; cyc = 0;
      exp_q.delete();
    end else begin
      logic [7:0] exp_b;
      bit tick_m, n_start;
      exp_b = m_valid ? exp_q[0] : m_last;
      check_eq("meas_start", meas_start, m_start);
      check_eq("busy", busy, m_busy);
      check_eq("tx_valid", tx_valid, m_valid);
      check_eq("tx_data", tx_data, exp_b);
      check_eq("overrun_cnt", overrun_cnt, m_ovr);
      check_eq("wait_bound", wait_expired, 0);
      if (sat_probe) check_eq("overrun_sat", overrun_cnt, 255);
      if (meas_start && !first_seen) begin
        first_seen = 1;
        if (chk_first) check_eq("first_start_cycle", cyc, first_exp);
      end
      if (tx_valid && tx_ready) n_acc++;

      // Advance the model to the next cycle.
      tick_m = ena && (m_phase == PERIOD - 1);
      if (ena) m_phase = (m_phase + 1) % PERIOD;
      n_start = 0;
      if (tick_m) begin
        if (m_busy) begin
          if (m_ovr < 255) m_ovr++;
        end else n_start = 1;
      end
      if (m_start) begin
        m_waiting = 1;
        m_wait_n  = 0;
      end else if (m_waiting) begin
        m_wait_n++;
        if (meas_done) build_frame(temp_data, sign, 1'b0);
        else if (m_wait_n == TIMEOUT) build_frame(16'h0000, 1'b0, 1'b1);
      end else if (m_valid && tx_ready) begin
        m_last = exp_q.pop_front();
        if (exp_q.size() == 0) begin
          m_valid = 0;
          m_busy  = 0;
        end
      end
      m_start = n_start;
      if (n_start) m_busy = 1;
      cyc++;
    end
  end

  task automatic drive_ready();
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom % 10) < 7;
      2: begin
        tx_ready = (rdy_ph == 2);
        rdy_ph   = (rdy_ph + 1) % 3;
      end
      default: tx_ready = 1'b0;
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      meas_done = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) meas_done = 1'b1;
      end
      if (meas_start) begin
        if (rand_mode) done_delay = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 45);
        if (done_delay > 0) done_cd = done_delay;
      end
      drive_ready();
      if (rand_mode) begin
        ena       = ($urandom % 10) != 0;
        temp_data = 16'($urandom);
        sign      = 1'($urandom);
        if ($urandom % 64 == 0) meas_done = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int first);
    rst_n     = 1'b0;
    ena       = 1'b1;
    meas_done = 1'b0;
    done_cd   = 0;
    rdy_ph    = 0;
    chk_first = (first != 0);
    first_exp = first;
    drive_ready();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    #1 rst_n = 1'b0;

    // Nominal frames with a 10-cycle conversion.
    done_delay = 10; temp_data = 16'h0191; sign = 1'b0; rdy_mode = 0;
    do_reset(100);
    step(320);

    // Driver never answers: timeout frames.
    done_delay = 0;
    do_reset(100);
    step(250);

    // Backpressure pattern 0,0,1.
    done_delay = 10; temp_data = 16'h1234; sign = 1'b1; rdy_mode = 2;
    do_reset(100);
    step(250);

    // Stalled UART for 250 cycles after the frame starts: two dropped ticks.
    rdy_mode = 3;
    do_reset(100);
    step(350);
    rdy_mode = 0;
    step(200);

    // Long stall saturates the overrun counter.
    rdy_mode = 3; done_delay = 0;
    do_reset(100);
    step(30200);
    sat_probe = 1;
    step(1);
    sat_probe = 0;
    rdy_mode = 0;
    step(50);

    // Done on the last timeout cycle, then one cycle too late.
    done_delay = 40; temp_data = 16'hBEEF; sign = 1'b1;
    do_reset(100);
    step(150);
    done_delay = 41;
    step(170);

    // Done pulsed while idle is ignored.
    done_delay = 0;
    do_reset(100);
    step(20);
    meas_done = 1'b1;
    step(90);

    // ena low for 30 cycles delays the first tick by 30.
    done_delay = 10;
    do_reset(130);
    step(20);
    ena = 1'b0;
    step(30);
    ena = 1'b1;
    step(150);

    // Asynchronous reset while B2 is presented.
    temp_data = 16'h0191; sign = 1'b0;
    do_reset(100);
    base = n_acc;
    for (int i = 0; i < 400 && n_acc < base + 2; i++) step(1);
    if (n_acc < base + 2) wait_expired = 1;
    do_reset(100);
    step(150);

    // Random traffic.
    rand_mode = 1; rdy_mode = 1;
    do_reset(0);
    step(15000);
    rand_mode = 0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
